// File: rtl/dma_if_pkg.sv
// ---------------------------------------------------------------------------
// dma_if_pkg
// Shared definitions for the DMA write-descriptor scheduler.
//   STATUS_ERR_W : width of each port's completion status error code
//   port_state_e : per-port admit state (RUN admits descriptors, DRAIN waits
//                  for in-flight descriptors to complete, DRAINED is quiesced)
// ---------------------------------------------------------------------------
package dma_if_pkg;

   localparam int STATUS_ERR_W = 4;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } port_state_e;

endpackage

// File: rtl/dma_if_wr_sched_if.sv
// ---------------------------------------------------------------------------
// dma_if_wr_sched_if
// Descriptor handshake and completion status bundle for the write-descriptor
// scheduler. One bit (or one STATUS_ERR_W field) per requester port.
//   s_desc_valid / s_desc_ready : requester side handshake
//   m_desc_valid / m_desc_ready : handshake toward the write-descriptor mux
//   status_valid / status_error : per-port completion status from the mux
// Modports:
//   master : the environment (requesters, mux) driving the scheduler
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface dma_if_wr_sched_if
   import dma_if_pkg::*;
#(
   parameter int PORTS = 2
);

   logic [PORTS-1:0]              s_desc_valid;
   logic [PORTS-1:0]              s_desc_ready;
   logic [PORTS-1:0]              m_desc_valid;
   logic [PORTS-1:0]              m_desc_ready;
   logic [PORTS-1:0]              status_valid;
   logic [PORTS*STATUS_ERR_W-1:0] status_error;

   modport master (
      output s_desc_valid,
      output m_desc_ready,
      output status_valid,
      output status_error,
      input  s_desc_ready,
      input  m_desc_valid
   );

   modport slave (
      input  s_desc_valid,
      input  m_desc_ready,
      input  status_valid,
      input  status_error,
      output s_desc_ready,
      output m_desc_valid
   );

endinterface

// File: rtl/dma_if_wr_sched_port.sv
// ---------------------------------------------------------------------------
// dma_if_wr_sched_port
// Admission control and in-flight accounting for a single requester port.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   s_desc_valid    : requester descriptor valid
//   s_desc_ready    : requester descriptor ready (m_desc_ready gated by admit)
//   m_desc_valid    : valid toward the mux (s_desc_valid gated by admit)
//   m_desc_ready    : ready from the mux
//   status_valid    : completion for one in-flight descriptor
//   status_error    : completion error code, nonzero means error
//   port_enable     : static admit enable
//   drain_req       : request to stop admitting and wait for completions
//   flag_clear      : clears the sticky flags (a same-cycle set wins)
//   drained         : drain requested and nothing left in flight
//   outstanding     : in-flight descriptor count
//   err_flag        : sticky, a nonzero status_error was seen
//   underflow_flag  : sticky, a completion arrived with nothing in flight
//   timeout_flag    : sticky watchdog expiry
// Build option: DMA_IF_WR_SCHED_TIMEOUT_EN adds the completion watchdog;
// without it timeout_flag is constant 0 and TIMEOUT_CYCLES is ignored.
// ---------------------------------------------------------------------------
module dma_if_wr_sched_port
   import dma_if_pkg::*;
#(
   parameter int  MAX_OUTSTANDING = 16,
   parameter int  TIMEOUT_CYCLES  = 65535,
   localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_desc_valid,
   output logic                    s_desc_ready,
   output logic                    m_desc_valid,
   input  logic                    m_desc_ready,
   input  logic                    status_valid,
   input  logic [STATUS_ERR_W-1:0] status_error,
   input  logic                    port_enable,
   input  logic                    drain_req,
   input  logic                    flag_clear,
   output logic                    drained,
   output logic [CNT_WIDTH-1:0]    outstanding,
   output logic                    err_flag,
   output logic                    underflow_flag,
   output logic                    timeout_flag
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

   port_state_e          state;
   port_state_e          state_next;
   logic [CNT_WIDTH-1:0] count;
   logic                 allow;
   logic                 issue;
   logic                 cnt_zero;
   logic                 err_r;
   logic                 unf_r;

   assign cnt_zero = (count == '0);

   // Admit state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state and admit decision. allow depends only on registered state
   // and static inputs, so there is no path from m_desc_ready back into it.
   // A port that is already empty still passes through DRAIN for one cycle.
   always_comb begin
      state_next = state;
      allow      = 1'b0;
      drained    = 1'b0;
      case (state)
         RUN: begin
            allow = port_enable && (count < CNT_MAX);
            if (drain_req) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!drain_req) begin
               state_next = RUN;
            end else if (cnt_zero) begin
               state_next = DRAINED;
            end
         end
         DRAINED: begin
            drained = 1'b1;
            if (!drain_req) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   assign m_desc_valid = s_desc_valid & allow;
   assign s_desc_ready = m_desc_ready & allow;
   assign issue        = m_desc_valid & m_desc_ready;

   // In-flight count. An issue and a completion in the same cycle cancel.
   // A completion with nothing in flight leaves the count at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (issue && !status_valid) begin
         count <= count + CNT_WIDTH'(1);
      end else if (status_valid && !issue && !cnt_zero) begin
         count <= count - CNT_WIDTH'(1);
      end
   end

   // Sticky flags: a set in the same cycle as flag_clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         err_r <= (status_valid && (status_error != '0)) || (err_r && !flag_clear);
         unf_r <= (status_valid && !issue && cnt_zero) || (unf_r && !flag_clear);
      end
   end

   assign outstanding    = count;
   assign err_flag       = err_r;
   assign underflow_flag = unf_r;

`ifdef DMA_IF_WR_SCHED_TIMEOUT_EN
   localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

   logic [WD_WIDTH-1:0] wd_count;
   logic                to_r;

   // Watchdog: counts cycles with work in flight and no completion, restarts
   // on any completion or when the port is empty, and saturates at the limit.
   // The flag is raised on the cycle the counter reaches the limit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_count <= '0;
         to_r     <= 1'b0;
      end else begin
         if (status_valid || cnt_zero) begin
            wd_count <= '0;
         end else if (wd_count != WD_LIMIT) begin
            wd_count <= wd_count + WD_WIDTH'(1);
         end
         to_r <= (!status_valid && !cnt_zero && (wd_count == WD_LIMIT - WD_WIDTH'(1)))
                 || (to_r && !flag_clear);
      end
   end

   assign timeout_flag = to_r;
`else
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: rtl/dma_if_wr_sched.sv
// ---------------------------------------------------------------------------
// dma_if_wr_sched
// Write-descriptor scheduler: limits the number of in-flight descriptors per
// requester port, supports per-port drain/quiesce, and records sticky error,
// underflow and (optionally) watchdog flags.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   bus            : descriptor handshakes and completion status (slave side)
//   port_enable    : per-port static admit enable
//   drain_req      : per-port quiesce request
//   flag_clear     : per-port sticky flag clear
//   drained        : per-port quiesced indication
//   outstanding    : per-port in-flight count, CNT_WIDTH bits each
//   err_flag       : per-port sticky error flag
//   underflow_flag : per-port sticky underflow flag
//   timeout_flag   : per-port sticky watchdog flag
// Build option: define DMA_IF_WR_SCHED_TIMEOUT_EN to enable the watchdog
// (limit TIMEOUT_CYCLES); otherwise timeout_flag is tied to 0.
// ---------------------------------------------------------------------------
module dma_if_wr_sched
   import dma_if_pkg::*;
#(
   parameter int  PORTS           = 2,
   parameter int  MAX_OUTSTANDING = 16,
   parameter int  TIMEOUT_CYCLES  = 65535,
   localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   dma_if_wr_sched_if.slave           bus,
   input  logic [PORTS-1:0]           port_enable,
   input  logic [PORTS-1:0]           drain_req,
   input  logic [PORTS-1:0]           flag_clear,
   output logic [PORTS-1:0]           drained,
   output logic [PORTS*CNT_WIDTH-1:0] outstanding,
   output logic [PORTS-1:0]           err_flag,
   output logic [PORTS-1:0]           underflow_flag,
   output logic [PORTS-1:0]           timeout_flag
);

   // Ports are fully independent; each gets its own accounting slice.
   for (genvar i = 0; i < PORTS; i++) begin : g_port
      dma_if_wr_sched_port #(
         .MAX_OUTSTANDING (MAX_OUTSTANDING),
         .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
      ) u_port (
         .clk            (clk),
         .rst_n          (rst_n),
         .s_desc_valid   (bus.s_desc_valid[i]),
         .s_desc_ready   (bus.s_desc_ready[i]),
         .m_desc_valid   (bus.m_desc_valid[i]),
         .m_desc_ready   (bus.m_desc_ready[i]),
         .status_valid   (bus.status_valid[i]),
         .status_error   (bus.status_error[i*STATUS_ERR_W +: STATUS_ERR_W]),
         .port_enable    (port_enable[i]),
         .drain_req      (drain_req[i]),
         .flag_clear     (flag_clear[i]),
         .drained        (drained[i]),
         .outstanding    (outstanding[i*CNT_WIDTH +: CNT_WIDTH]),
         .err_flag       (err_flag[i]),
         .underflow_flag (underflow_flag[i]),
         .timeout_flag   (timeout_flag[i])
      );
   end

endmodule

// File: doc/dma_if_wr_sched.md
DMA_IF_WR_SCHED -- requirements
Module: dma_if_wr_sched

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of write-descriptor requester ports.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16: per-port in-flight descriptor limit (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: per-port watchdog limit, used only with the configuration macro.
REQ-004 SHALL have local CNT_WIDTH = $clog2(MAX_OUTSTANDING+1).
REQ-005 SHALL have one clock and a synchronous, active-low reset; ports clk and rst_n.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 s_desc_valid  input  PORTS  requester descriptor valid.
REQ-009 s_desc_ready  output  PORTS  requester descriptor ready.
REQ-010 m_desc_valid  output  PORTS  valid toward write-descriptor mux inputs.
REQ-011 m_desc_ready  input  PORTS  ready from write-descriptor mux inputs.
REQ-012 status_valid  input  PORTS  per-port completion status from mux status outputs.
REQ-013 status_error  input  PORTS*4  per-port status error code.
REQ-014 port_enable  input  PORTS  static admit enable per port.
REQ-015 drain_req  input  PORTS  request quiesce of port.
REQ-016 drained  output  PORTS  port quiesced: drain active and zero outstanding.
REQ-017 outstanding  output  PORTS*CNT_WIDTH  current in-flight count per port.
REQ-018 err_flag  output  PORTS  sticky: nonzero status_error seen.
REQ-019 underflow_flag  output  PORTS  sticky: status_valid with count 0.
REQ-020 timeout_flag  output  PORTS  sticky watchdog expiry.
REQ-021 flag_clear  input  PORTS  clears the three sticky flags of a port.

Function
REQ-022 allow[i] = port_enable[i] & ~state DRAIN/DRAINED & (count[i] < MAX_OUTSTANDING), registered-state only (no comb path from m_desc_ready).
REQ-023 m_desc_valid[i] = s_desc_valid[i] & allow[i]; s_desc_ready[i] = m_desc_ready[i] & allow[i]; zero added latency.
REQ-024 Issue event = m_desc_valid[i] & m_desc_ready[i]: count +1 next cycle.
REQ-025 status_valid[i]: count -1 next cycle; issue and status in same cycle: count unchanged.
REQ-026 status_valid[i] with count 0 and no same-cycle issue: count stays 0, underflow_flag set.
REQ-027 status_valid[i] with status_error != 0: err_flag set; decrement still applies.
REQ-028 Per-port FSM: RUN -> DRAIN when drain_req; DRAIN -> DRAINED when count = 0 (same cycle if already 0 -> DRAINED next cycle); DRAIN/DRAINED -> RUN when drain_req deasserted.
REQ-029 drained[i] asserted only in DRAINED.
REQ-030 At count = MAX_OUTSTANDING, s_desc_ready low until a status decrements it; re-admit the cycle after.
REQ-031 flag_clear has priority below same-cycle set (set wins).

Reset
REQ-032 On rst_n low at clock edge: count 0, FSM RUN, all sticky flags 0, watchdog 0; outputs drained 0, outstanding 0, flags 0; m_desc_valid/s_desc_ready follow REQ-023 with reset state.
REQ-033 Reset mid-operation discards in-flight accounting; later status for pre-reset descriptors sets underflow_flag.

Configuration
REQ-034 Macro DMA_IF_WR_SCHED_TIMEOUT_EN defined: per-port watchdog counts cycles with count > 0 and no status_valid; reloads 0 on status_valid or count = 0; sets timeout_flag on reaching TIMEOUT_CYCLES, saturates.
REQ-035 Macro undefined: no watchdog logic; timeout_flag tied 0.

Structure
REQ-036 Shared package dma_if_pkg SHALL hold FSM state encoding (RUN, DRAIN, DRAINED) and status error width constant 4.
REQ-037 Per-port logic SHALL be one sub-module dma_if_wr_sched_port, instantiated PORTS times via generate.

Verification
REQ-038 MAX_OUTSTANDING=4, port 0 issues 6 back-to-back with m_desc_ready=1 -> 4 accepted, s_desc_ready[0]=0, outstanding=4; one status -> 5th accepted next cycle.
REQ-039 Issue and status same cycle at count 2 -> count stays 2.
REQ-040 drain_req with count 3, three statuses -> drained=1 one cycle after count 0; no descriptor accepted during DRAIN.
REQ-041 status_valid at count 0 -> underflow_flag=1, count 0; flag_clear -> flag 0 next cycle.
REQ-042 status_error=4'h2 -> err_flag=1, count decremented.
REQ-043 TIMEOUT_EN, TIMEOUT_CYCLES=10, one outstanding, no status -> timeout_flag=1 after 10 cycles; macro off -> stays 0.
